// File: rtl/axis_packetizer_pkg.sv
// Shared stream constants and framing state encoding for the packetizer
// and the memory controller/memory stream path.
package axis_packetizer_pkg;

   localparam int AXIS_DATA_WIDTH = 32;
   localparam int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } pkt_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// 2-entry register slice (output register + skid register), strict FIFO order.
// Latency: 1 cycle from input acceptance to output valid.
// Backpressure: absorbs one beat on a stall; in_rdy is registered and low only while the skid is full.
module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_dat,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic [WIDTH-1:0] out_dat,
   output logic             out_vld,
   input  logic             out_rdy
);

   logic [WIDTH-1:0] skid_dat;
   logic             skid_vld;
   logic             in_fire;
   logic             out_free;

   assign in_fire  = in_vld && in_rdy;
   assign out_free = !out_vld || out_rdy;

   // in_rdy always equals !skid_vld outside reset, so no beat can arrive while the skid is occupied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_dat  <= '0;
         out_vld  <= 1'b0;
         skid_dat <= '0;
         skid_vld <= 1'b0;
         in_rdy   <= 1'b0;
      end else if (out_free) begin
         in_rdy <= 1'b1;
         if (skid_vld) begin
            out_dat  <= skid_dat;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
         end else begin
            out_vld <= in_fire;
            if (in_fire) begin
               out_dat <= in_dat;
            end
         end
      end else if (in_fire) begin
         skid_dat <= in_dat;
         skid_vld <= 1'b1;
         in_rdy   <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_packetizer.sv
// Frames an unframed AXI-Stream into cfg_frame_len-beat frames, tagging the last beat with tlast.
// Latency: 1 cycle (beat accepted at edge N is on m00_* after edge N).
// Backpressure: 2-entry skid buffer, registered s00_axis_tready, full rate while m00_axis_tready is high.
module axis_packetizer
   import axis_packetizer_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                    s00_axis_aclk,
   input  logic                    s00_axis_aresetn,
   input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                    s00_axis_tvalid,
   input  logic                    s00_axis_tlast,
   output logic                    s00_axis_tready,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tvalid,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready,
   output logic [15:0]             frames_sent,
   output logic                    short_frame
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int BUF_WIDTH  = DATA_WIDTH + STRB_WIDTH + 1;

   pkt_state_e           state;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic [LEN_WIDTH-1:0] cnt_inc;
   logic                 in_fire;
   logic                 out_fire;
   logic                 len_hit;
   logic                 tag_last;
   logic [BUF_WIDTH-1:0] buf_in;
   logic [BUF_WIDTH-1:0] buf_out;

   assign in_fire  = s00_axis_tvalid && s00_axis_tready;
   assign out_fire = m00_axis_tvalid && m00_axis_tready;
   assign cnt_inc  = beat_cnt + LEN_WIDTH'(1);

   // A length of 0 behaves as 1, so anything <= 1 closes the frame on its first beat.
   always_comb begin
      len_hit = 1'b0;
      if (state == IDLE) begin
         len_hit = (cfg_frame_len <= LEN_WIDTH'(1));
      end else begin
         len_hit = (cnt_inc == len_q);
      end
      tag_last = len_hit || s00_axis_tlast;
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state       <= IDLE;
         len_q       <= '0;
         beat_cnt    <= '0;
         short_frame <= 1'b0;
      end else begin
         short_frame <= in_fire && s00_axis_tlast && !len_hit;
         if (in_fire) begin
            if (state == IDLE) begin
               len_q    <= (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
               beat_cnt <= LEN_WIDTH'(1);
               state    <= tag_last ? IDLE : ACTIVE;
            end else begin
               beat_cnt <= cnt_inc;
               if (tag_last) begin
                  state <= IDLE;
               end
            end
         end
      end
   end

   // Frames count on downstream acceptance of the tlast beat, not on tagging.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         frames_sent <= '0;
      end else if (out_fire && m00_axis_tlast) begin
         frames_sent <= frames_sent + 16'd1;
      end
   end

   assign buf_in = {s00_axis_tdata, s00_axis_tstrb, tag_last};

   axis_skid_buffer #(
      .WIDTH (BUF_WIDTH)
   ) u_skid (
      .clk     (s00_axis_aclk),
      .rst_n   (s00_axis_aresetn),
      .in_dat  (buf_in),
      .in_vld  (s00_axis_tvalid),
      .in_rdy  (s00_axis_tready),
      .out_dat (buf_out),
      .out_vld (m00_axis_tvalid),
      .out_rdy (m00_axis_tready)
   );

   assign {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast} = buf_out;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: drives at the falling edge, samples at the falling edge.
`timescale 1ns/1ps
module tb_axis_packetizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] cfg_len;
   logic [31:0] s_tdata;
   logic [3:0]  s_tstrb;
   logic        s_tvalid, s_tlast, s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic        m_tvalid, m_tlast, m_tready;
   logic [15:0] frames_sent;
   logic        short_frame;

   int vectors = 0, miscompares = 0;
   int timeouts = 0, stall_viol = 0, rdy_viol = 0, short_cnt = 0, ticks = 0;
   logic rec = 1'b1, bp_mon = 1'b0, tog = 1'b1, saw_not_rdy = 1'b0, prev_stall = 1'b0;
   logic [37:0] prev_out = '0;
   logic [36:0] rx[$];
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   axis_packetizer dut (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst_n),
      .cfg_frame_len    (cfg_len),
      .s00_axis_tdata   (s_tdata),
      .s00_axis_tstrb   (s_tstrb),
      .s00_axis_tvalid  (s_tvalid),
      .s00_axis_tlast   (s_tlast),
      .s00_axis_tready  (s_tready),
      .m00_axis_tdata   (m_tdata),
      .m00_axis_tstrb   (m_tstrb),
      .m00_axis_tvalid  (m_tvalid),
      .m00_axis_tlast   (m_tlast),
      .m00_axis_tready  (m_tready),
      .frames_sent      (frames_sent),
      .short_frame      (short_frame)
   );

   function automatic logic [3:0] strb_of(input logic [31:0] d);
      return d[3:0] ^ 4'h5;
   endfunction

   function automatic logic [36:0] beat(input logic [31:0] d, input logic l);
      return {l, strb_of(d), d};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: apply inputs, note what the coming edge will transfer, advance to next falling edge.
   task automatic tick(input logic sv, input logic [31:0] d, input logic tl, input logic mr,
                       output logic acc);
      s_tvalid = sv;
      s_tdata  = d;
      s_tstrb  = strb_of(d);
      s_tlast  = tl;
      m_tready = mr;
      acc = sv && s_tready;
      if (prev_stall && ({m_tvalid, m_tlast, m_tstrb, m_tdata} !== prev_out)) stall_viol++;
      if (bp_mon && !s_tready) begin
         saw_not_rdy = 1'b1;
         if (!prev_stall) rdy_viol++;
      end
      if (m_tvalid && mr && rec) rx.push_back({m_tlast, m_tstrb, m_tdata});
      if (short_frame) short_cnt++;
      prev_stall = m_tvalid && !mr;
      prev_out   = {m_tvalid, m_tlast, m_tstrb, m_tdata};
      ticks++;
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] d, input logic tl, input logic toggle);
      logic acc;
      logic mr;
      int   g;
      acc = 1'b0;
      g = 0;
      while (!acc && g < 50) begin
         mr = toggle ? tog : 1'b1;
         if (toggle) tog = ~tog;
         tick(1'b1, d, tl, mr, acc);
         g++;
      end
      if (!acc) timeouts++;
   endtask

   task automatic drain();
      logic acc;
      int   g;
      g = 0;
      while (m_tvalid && g < 20) begin
         tick(1'b0, 32'h0, 1'b0, 1'b1, acc);
         g++;
      end
      if (m_tvalid) timeouts++;
   endtask

   task automatic compare_rx(input string tag);
      check({tag, "_count"}, 64'(rx.size()), 64'(exp_q.size()));
      for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
         check(tag, 64'(rx[i]), 64'(exp_q[i]));
   endtask

   task automatic clear_q();
      rx.delete();
      exp_q.delete();
   endtask

   initial begin
      logic acc;
      int   nl, li, t0;

      // Reset state
      rst_n = 1'b0; cfg_len = 12'd4; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0;
      s_tlast = 1'b0; m_tready = 1'b1;
      @(negedge clk); @(negedge clk);
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_out", 64'({m_tlast, m_tstrb, m_tdata}), 64'd0);
      check("rst_frames", 64'(frames_sent), 64'd0);
      check("rst_short", 64'(short_frame), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_tready", 64'(s_tready), 64'd1);

      // Basic framing, length 4, data 0..B, full rate
      clear_q(); cfg_len = 12'd4; short_cnt = 0; t0 = ticks;
      send(32'h0, 1'b0, 1'b0);
      check("latency_vld", 64'(m_tvalid), 64'd1);
      check("latency_beat", 64'({m_tlast, m_tstrb, m_tdata}), 64'(beat(32'h0, 1'b0)));
      for (int i = 1; i < 12; i++) send(32'(i), 1'b0, 1'b0);
      check("throughput_ticks", 64'(ticks - t0), 64'd12);
      check("throughput_out", 64'(rx.size()), 64'd11);
      drain();
      for (int i = 0; i < 12; i++) exp_q.push_back(beat(32'(i), (i % 4) == 3));
      compare_rx("basic");
      check("basic_frames", 64'(frames_sent), 64'd3);
      check("basic_short", 64'(short_cnt), 64'd0);

      // Early terminate on 3rd beat, then a full 8-beat frame
      clear_q(); cfg_len = 12'd8; short_cnt = 0;
      send(32'h10, 1'b0, 1'b0);
      send(32'h11, 1'b0, 1'b0);
      send(32'h12, 1'b1, 1'b0);
      check("short_pulse", 64'(short_frame), 64'd1);
      for (int i = 0; i < 8; i++) send(32'h13 + 32'(i), 1'b0, 1'b0);
      drain();
      exp_q.push_back(beat(32'h10, 1'b0));
      exp_q.push_back(beat(32'h11, 1'b0));
      exp_q.push_back(beat(32'h12, 1'b1));
      for (int i = 0; i < 8; i++) exp_q.push_back(beat(32'h13 + 32'(i), i == 7));
      compare_rx("early");
      check("early_short_cnt", 64'(short_cnt), 64'd1);
      check("early_frames", 64'(frames_sent), 64'd5);

      // Backpressure: downstream ready toggles every cycle
      clear_q(); cfg_len = 12'd5; tog = 1'b1; bp_mon = 1'b1; stall_viol = 0; rdy_viol = 0;
      for (int i = 0; i < 20; i++) send(32'h20 + 32'(i), 1'b0, 1'b1);
      drain();
      bp_mon = 1'b0;
      for (int i = 0; i < 20; i++) exp_q.push_back(beat(32'h20 + 32'(i), (i % 5) == 4));
      compare_rx("bp");
      check("bp_frames", 64'(frames_sent), 64'd9);
      check("bp_stable", 64'(stall_viol), 64'd0);
      check("bp_tready_rule", 64'(rdy_viol), 64'd0);
      check("bp_skid_used", 64'(saw_not_rdy), 64'd1);

      // Lengths 0 and 1: every beat is last
      clear_q(); cfg_len = 12'd0;
      for (int i = 0; i < 3; i++) send(32'h30 + 32'(i), 1'b0, 1'b0);
      cfg_len = 12'd1;
      for (int i = 0; i < 3; i++) send(32'h40 + 32'(i), 1'b0, 1'b0);
      drain();
      for (int i = 0; i < 3; i++) exp_q.push_back(beat(32'h30 + 32'(i), 1'b1));
      for (int i = 0; i < 3; i++) exp_q.push_back(beat(32'h40 + 32'(i), 1'b1));
      compare_rx("len01");
      check("len01_frames", 64'(frames_sent), 64'd15);

      // Maximum length 4095
      clear_q(); cfg_len = 12'd4095;
      for (int i = 0; i < 4095; i++) send(32'(i), 1'b0, 1'b0);
      drain();
      nl = 0; li = -1;
      foreach (rx[i]) if (rx[i][36]) begin nl++; li = i; end
      check("len4095_count", 64'(rx.size()), 64'd4095);
      check("len4095_nlast", 64'(nl), 64'd1);
      check("len4095_lastidx", 64'(li), 64'd4094);
      check("len4095_frames", 64'(frames_sent), 64'd16);

      // Length change mid-frame only affects the next frame
      clear_q(); cfg_len = 12'd3;
      send(32'h50, 1'b0, 1'b0);
      cfg_len = 12'd6;
      send(32'h51, 1'b0, 1'b0);
      send(32'h52, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) send(32'h53 + 32'(i), 1'b0, 1'b0);
      drain();
      exp_q.push_back(beat(32'h50, 1'b0));
      exp_q.push_back(beat(32'h51, 1'b0));
      exp_q.push_back(beat(32'h52, 1'b1));
      for (int i = 0; i < 6; i++) exp_q.push_back(beat(32'h53 + 32'(i), i == 5));
      compare_rx("midchg");
      check("midchg_frames", 64'(frames_sent), 64'd18);

      // frames_sent wrap
      rec = 1'b0; cfg_len = 12'd1;
      for (int i = 0; i < 65517; i++) send(32'(i), 1'b0, 1'b0);
      drain();
      check("wrap_ffff", 64'(frames_sent), 64'hFFFF);
      send(32'h0, 1'b0, 1'b0);
      drain();
      check("wrap_zero", 64'(frames_sent), 64'd0);
      rec = 1'b1;

      // Reset mid-frame with the skid register full
      clear_q(); cfg_len = 12'd6;
      send(32'h60, 1'b0, 1'b0);
      tick(1'b1, 32'h61, 1'b0, 1'b0, acc);
      check("skid_fill_acc", 64'(acc), 64'd1);
      check("skid_full_tready", 64'(s_tready), 64'd0);
      s_tvalid = 1'b0; m_tready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("midrst_tready", 64'(s_tready), 64'd0);
      check("midrst_tvalid", 64'(m_tvalid), 64'd0);
      check("midrst_out", 64'({m_tlast, m_tstrb, m_tdata}), 64'd0);
      check("midrst_frames", 64'(frames_sent), 64'd0);
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_release_tready", 64'(s_tready), 64'd1);
      clear_q();
      for (int i = 0; i < 6; i++) send(32'h70 + 32'(i), 1'b0, 1'b0);
      drain();
      for (int i = 0; i < 6; i++) exp_q.push_back(beat(32'h70 + 32'(i), i == 5));
      compare_rx("after_rst");
      check("after_rst_frames", 64'(frames_sent), 64'd1);

      check("timeouts", 64'(timeouts), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

- Upstream framing stage for the memory controller/memory stream path.
- Accepts an unframed AXI-Stream of data beats and registers each beat.
- Marks the last beat of every frame with `tlast`, giving the downstream memory slave port well-formed frames of a programmable length.
- Uses a 2-entry skid buffer so it sustains one beat per clock with registered `tready`.

## Interface

**Parameters**

- `DATA_WIDTH`, default 32: beat width in bits; must be a multiple of 8.
- `LEN_WIDTH`, default 12: width of the frame-length configuration and the beat counter.

**Ports** (name, direction, width, meaning)

- `s00_axis_aclk`, in, 1: the single clock for all logic.
- `s00_axis_aresetn`, in, 1: asynchronous, active-low reset.
- `cfg_frame_len`, in, `LEN_WIDTH`: beats per frame; sampled at frame start.
- `s00_axis_tdata`, in, `DATA_WIDTH`: input beat.
- `s00_axis_tstrb`, in, `DATA_WIDTH/8`: byte strobes; passed through unchanged.
- `s00_axis_tvalid`, in, 1: input beat valid.
- `s00_axis_tlast`, in, 1: upstream early-terminate request.
- `s00_axis_tready`, out, 1: input ready; registered.
- `m00_axis_tdata`, out, `DATA_WIDTH`: output beat.
- `m00_axis_tstrb`, out, `DATA_WIDTH/8`: output strobes.
- `m00_axis_tvalid`, out, 1: output beat valid.
- `m00_axis_tlast`, out, 1: last beat of frame.
- `m00_axis_tready`, in, 1: downstream ready.
- `frames_sent`, out, 16: count of completed frames; wraps from 0xFFFF to 0.
- `short_frame`, out, 1: one-cycle pulse when a frame is closed early by `s00_axis_tlast`.

## Operation

**States: IDLE and ACTIVE.**
- IDLE: no frame is open.
  - On an accepted input beat (`s00_axis_tvalid && s00_axis_tready`), latch `cfg_frame_len` into `len_q`.
  - An `len_q` of 0 is treated as 1.
  - Set `beat_cnt` = 1.
  - If the frame is a single beat (length ≤ 1) or `s00_axis_tlast` is high, tag the beat `last` and stay in IDLE.
  - Otherwise go to ACTIVE.
- ACTIVE: on each accepted beat, increment `beat_cnt`.
  - If `beat_cnt + 1 == len_q`, tag the beat `last` and return to IDLE.
  - If `s00_axis_tlast` arrives before that point, tag the beat `last`, return to IDLE, and pulse `short_frame`.

**Frame length and counting**
- `cfg_frame_len` changes during ACTIVE are ignored until the next frame start.
- The counter compare is `LEN_WIDTH` bits wide and unsigned.

**Data path and buffering**
- The tagged beat `{tdata, tstrb, last}` enters a 2-entry buffer: an output register plus a skid register.
- `s00_axis_tready` is low when the skid register is full, and is registered.
- Output ordering is strict FIFO.
- `frames_sent` increments when a beat with `m00_axis_tlast` is accepted downstream (`m00_axis_tvalid && m00_axis_tready`), not when it is tagged.

## Timing

**Reset values** (asynchronous assertion, deasserted synchronously to the clock)
- `s00_axis_tready` = 0 during reset and 1 in the first cycle after reset release.
- `m00_axis_tvalid`, `m00_axis_tlast`, `m00_axis_tdata`, `m00_axis_tstrb` = 0.
- `frames_sent` = 0; `short_frame` = 0.
- State = IDLE; `beat_cnt` = 0; buffers empty.

**Latency**
- 1 cycle: a beat accepted at edge N is presented on `m00_*` after edge N with `m00_axis_tvalid` high.

**Throughput**
- 1 beat per clock while `m00_axis_tready` stays high.

**Handshake rules**
- While `m00_axis_tvalid` is high and `m00_axis_tready` is low, all `m00_*` outputs hold stable.
- On a downstream stall, one more input beat is absorbed into the skid register; `s00_axis_tready` drops in the following cycle.
- When the stall releases, the skid beat drains first, then `s00_axis_tready` reasserts.

**Simultaneous events**
- Length boundary and `s00_axis_tlast` in the same beat: a normal frame end; no `short_frame` pulse.
- `short_frame` and `m00` output are independent: `short_frame` pulses in the cycle after the tagging acceptance.

**Reset mid-frame**
- Any open frame and any buffered beats are discarded.
- No `tlast` is emitted for the discarded frame.

## Structure

- Shared package holds:
  - `AXIS_DATA_WIDTH` = 32 and `AXIS_STRB_WIDTH`, shared with the memory controller and memory.
  - The state enum `{IDLE, ACTIVE}`.
- One sub-module, `axis_skid_buffer`: the parameterised 2-entry register slice carrying `{tdata, tstrb, tlast}`, reusable at other stream boundaries.
- Framing FSM, counter, and status counters live in the top level.

## Test plan

- **Basic framing:** `cfg_frame_len`=4, 12 back-to-back beats with data 0x0..0xB, `m00_axis_tready` held high → `tlast` on data 0x3, 0x7, 0xB; `frames_sent`=3; one beat out per cycle.
- **Early terminate:** `cfg_frame_len`=8, `s00_axis_tlast` on the 3rd beat → output `tlast` on the 3rd beat; one `short_frame` pulse; the next frame starts counting from 1.
- **Backpressure:** `m00_axis_tready` toggles 1/0 every cycle, `cfg_frame_len`=5, 20 beats → no loss, duplication or reordering; `m00_*` stable while stalled; `s00_axis_tready` never low with the skid register empty.
- **Length edge cases:**
  - `cfg_frame_len`=0 and =1 → every beat carries `tlast`.
  - `cfg_frame_len`=4095 → `tlast` on beat 4095 only.
  - Changing `cfg_frame_len` mid-frame → the open frame is unaffected.
- **Counter wrap:** `frames_sent` preloaded by running 65536 single-beat frames → wraps from 0xFFFF to 0x0000.
- **Reset mid-frame:** assert `s00_axis_aresetn` low on beat 2 of a 6-beat frame with the skid register full → all outputs go to reset values immediately; after release, the next frame's `tlast` falls on its own 6th beat.
